// File: rtl/scarv_cop_insn_ctrl_pkg.sv
// Shared encodings for the COP instruction sequencer: FSM states, result codes,
// instruction class/subclass constants and the FU routing helpers.
package scarv_cop_insn_ctrl_pkg;

    typedef enum logic [1:0] {
        CTL_IDLE = 2'd0,
        CTL_EXEC = 2'd1,
        CTL_RESP = 2'd2
    } ctl_state_t;

    typedef enum logic [2:0] {
        RES_SUCCESS = 3'd0,
        RES_ABORT   = 3'd1,
        RES_BAD_INS = 3'd2,
        RES_TIMEOUT = 3'd3,
        RES_BAD_LAD = 3'd4,
        RES_BAD_SAD = 3'd5,
        RES_LD_ERR  = 3'd6,
        RES_ST_ERR  = 3'd7
    } cop_result_t;

    localparam logic [2:0] ICLASS_PACKED_ARITH = 3'd1;
    localparam logic [2:0] ICLASS_TWIDDLE      = 3'd2;
    localparam logic [2:0] ICLASS_LOADSTORE    = 3'd3;
    localparam logic [2:0] ICLASS_MOVE         = 3'd5;
    localparam logic [2:0] ICLASS_MP           = 3'd6;
    localparam logic [2:0] ICLASS_BITWISE      = 3'd7;

    localparam logic [3:0] SUBCLASS_MV2GPR = 4'd1;

    // Load/store subclasses with this bit set are stores.
    localparam int LS_STORE_BIT = 3;

    typedef enum logic [1:0] {
        FU_NONE = 2'd0,
        FU_PALU = 2'd1,
        FU_MALU = 2'd2,
        FU_MEM  = 2'd3
    } fu_sel_t;

    function automatic fu_sel_t fu_select(input logic [2:0] cls);
        case (cls)
            ICLASS_PACKED_ARITH,
            ICLASS_MOVE,
            ICLASS_BITWISE,
            ICLASS_TWIDDLE:   return FU_PALU;
            ICLASS_MP:        return FU_MALU;
            ICLASS_LOADSTORE: return FU_MEM;
            default:          return FU_NONE;
        endcase
    endfunction

    function automatic logic is_store(input logic [3:0] subclass);
        return subclass[LS_STORE_BIT];
    endfunction

endpackage

// File: rtl/scarv_cop_ctrl_timer.sv
// EXEC watchdog: cleared outside EXEC, counts EXEC cycles, flags the last
// permitted cycle before the sequencer forces a TIMEOUT completion.
module scarv_cop_ctrl_timer #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic g_clk,
    input  logic g_reset,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    logic [CNT_W-1:0] count_q;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (inc) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign expired = (count_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/scarv_cop_insn_ctrl.sv
// COP instruction sequencer: accepts one instruction, dispatches it to a single
// functional unit, gates CPR commit on completion and returns a registered response.
module scarv_cop_insn_ctrl
    import scarv_cop_insn_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        g_clk,
    input  logic        g_reset,

    input  logic        cpu_insn_req,
    output logic        cop_insn_ack,
    input  logic        cpu_abort_req,
    input  logic [31:0] cpu_insn_enc,
    input  logic [31:0] cpu_rs1,

    output logic        cop_insn_rsp,
    input  logic        cpu_insn_ack,
    output logic [2:0]  cop_result,
    output logic        cop_wen,
    output logic [4:0]  cop_waddr,
    output logic [31:0] cop_wdata,

    output logic [31:0] ctl_insn_enc,
    output logic [31:0] ctl_rs1,

    input  logic        id_exception,
    input  logic [2:0]  id_class,
    input  logic [3:0]  id_subclass,
    input  logic [4:0]  id_rd,

    output logic        palu_ivalid,
    output logic        malu_ivalid,
    output logic        mem_ivalid,
    input  logic        palu_idone,
    input  logic        malu_idone,
    input  logic        mem_idone,
    input  logic        mem_addr_error,
    input  logic        mem_bus_error,
    input  logic [31:0] palu_gpr_wdata,

    output logic        cpr_wen_gate
);

    ctl_state_t  state_q, state_d;
    cop_result_t result_q, result_d;
    fu_sel_t     fu_sel;
    logic        fu_done;
    logic        finish;
    logic        capture_mv;
    logic        timer_expired;
    logic        wen_q;

    assign fu_sel = fu_select(id_class);

    // Only the selected unit's completion is honoured.
    always_comb begin
        fu_done = 1'b0;
        case (fu_sel)
            FU_PALU: fu_done = palu_idone;
            FU_MALU: fu_done = malu_idone;
            FU_MEM:  fu_done = mem_idone;
            default: fu_done = 1'b0;
        endcase
    end

    scarv_cop_ctrl_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_timer (
        .g_clk   (g_clk),
        .g_reset (g_reset),
        .clr     (state_q != CTL_EXEC),
        .inc     (state_q == CTL_EXEC),
        .expired (timer_expired)
    );

    // NOTE: every output of this block is defaulted first so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        result_d     = result_q;
        finish       = 1'b0;
        capture_mv   = 1'b0;
        cop_insn_ack = 1'b0;
        cop_insn_rsp = 1'b0;
        palu_ivalid  = 1'b0;
        malu_ivalid  = 1'b0;
        mem_ivalid   = 1'b0;
        cpr_wen_gate = 1'b0;

        case (state_q)
            CTL_IDLE: begin
                cop_insn_ack = 1'b1;
                if (cpu_insn_req) begin
                    state_d = CTL_EXEC;
                end
            end

            CTL_EXEC: begin
                if (id_exception || fu_sel == FU_NONE) begin
                    finish   = 1'b1;
                    result_d = RES_BAD_INS;
                end else begin
                    palu_ivalid = (fu_sel == FU_PALU);
                    malu_ivalid = (fu_sel == FU_MALU);
                    mem_ivalid  = (fu_sel == FU_MEM);

                    // Completion beats a same-cycle abort or timeout.
                    if (fu_done) begin
                        finish       = 1'b1;
                        cpr_wen_gate = 1'b1;
                        capture_mv   = (id_class == ICLASS_MOVE) &&
                                       (id_subclass == SUBCLASS_MV2GPR);
                        result_d     = RES_SUCCESS;
                        if (fu_sel == FU_MEM && mem_addr_error) begin
                            result_d = is_store(id_subclass) ? RES_BAD_SAD : RES_BAD_LAD;
                        end else if (fu_sel == FU_MEM && mem_bus_error) begin
                            result_d = is_store(id_subclass) ? RES_ST_ERR : RES_LD_ERR;
                        end
                    end else if (cpu_abort_req) begin
                        finish   = 1'b1;
                        result_d = RES_ABORT;
                    end else if (timer_expired) begin
                        finish   = 1'b1;
                        result_d = RES_TIMEOUT;
                    end
                end
                if (finish) begin
                    state_d = CTL_RESP;
                end
            end

            CTL_RESP: begin
                cop_insn_rsp = 1'b1;
                if (cpu_insn_ack) begin
                    state_d = CTL_IDLE;
                end
            end

            default: state_d = CTL_IDLE;
        endcase
    end

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            state_q      <= CTL_IDLE;
            ctl_insn_enc <= '0;
            ctl_rs1      <= '0;
            result_q     <= RES_SUCCESS;
            wen_q        <= 1'b0;
            cop_waddr    <= '0;
            cop_wdata    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == CTL_IDLE && cpu_insn_req) begin
                ctl_insn_enc <= cpu_insn_enc;
                ctl_rs1      <= cpu_rs1;
            end
            // wen is only ever set on entry to RESP and dropped on exit.
            if (finish) begin
                result_q <= result_d;
                wen_q    <= capture_mv;
                if (capture_mv) begin
                    cop_waddr <= id_rd;
                    cop_wdata <= palu_gpr_wdata;
                end
            end else if (state_q == CTL_RESP && cpu_insn_ack) begin
                wen_q <= 1'b0;
            end
        end
    end

    assign cop_result = result_q;
    assign cop_wen    = wen_q;

endmodule
